lmg_scheduler: RTL



---
 rtl/chess_pkg.sv | 41 ++++
 rtl/move_list_writer.sv | 48 ++++
 rtl/lmg_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the legal-move-generator datapath: piece codes,
// board/move-list layout constants and the scheduler state encoding.
package chess_pkg;

    // Piece type codes held in bits 2:0 of a board nibble
    localparam logic [2:0] PIECE_EMPTY   = 3'd0;
    localparam logic [2:0] PIECE_PAWN    = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT  = 3'd2;
    localparam logic [2:0] PIECE_BISHOP  = 3'd3;
    localparam logic [2:0] PIECE_ROOK    = 3'd4;
    localparam logic [2:0] PIECE_QUEEN   = 3'd5;
    localparam logic [2:0] PIECE_KING    = 3'd6;
    localparam logic [2:0] PIECE_INVALID = 3'd7;

    // Bit 3 of a nibble is the color, 1 = black
    localparam int COLOR_BIT = 3;

    // Slave word holding board row 0; row r lives at BOARD_BASE + r
    localparam int BOARD_BASE = 2;

    // Slave word of the first move-list entry
    localparam int MOVE_BASE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SCAN,
        ST_DISPATCH,
        ST_COLLECT,
        ST_DONE
    } lmg_state_t;

    // True for a real piece (not empty, not the unused type 7) of the side to move
    function automatic logic is_own_piece(input logic [3:0] nibble, input logic side);
        logic [2:0] kind;
        kind = nibble[2:0];
        return (nibble[COLOR_BIT] == side) && (kind != PIECE_EMPTY) && (kind != PIECE_INVALID);
    endfunction

endpackage

// File: rtl/move_list_writer.sv
// Move-list write port: turns accepted move beats into registered RAM writes,
// tracks how many moves were stored and flags drops once the list is full.
module move_list_writer
    import chess_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int MOVE_BASE  = MOVE_BASE_DEFAULT,
    parameter int MAX_MOVES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [15:0]           beat_move,
    output logic                  ml_we,
    output logic [ADDR_WIDTH-1:0] ml_addr,
    output logic [DATA_WIDTH-1:0] ml_wdata,
    output logic [8:0]            move_count,
    output logic                  overflow
);

    localparam logic [8:0] CAPACITY = 9'(MAX_MOVES);

    // Register one write per stored move; beyond capacity the move is dropped and flagged
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ml_we      <= 1'b0;
            ml_addr    <= '0;
            ml_wdata   <= '0;
            move_count <= '0;
            overflow   <= 1'b0;
        end else begin
            ml_we <= 1'b0;
            if (beat_valid) begin
                if (move_count < CAPACITY) begin
                    ml_we      <= 1'b1;
                    ml_addr    <= ADDR_WIDTH'(MOVE_BASE) + ADDR_WIDTH'(move_count);
                    ml_wdata   <= DATA_WIDTH'(beat_move);
                    move_count <= move_count + 9'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lmg_scheduler.sv
// LMG sequencer: walks the eight board rows square by square, hands every
// piece of the side to move to the move generator and streams the returned
// moves into the move list through move_list_writer.
module lmg_scheduler
    import chess_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int MOVE_BASE  = MOVE_BASE_DEFAULT,
    parameter int MAX_MOVES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  side,
    output logic [2:0]            board_addr,
    input  logic [DATA_WIDTH-1:0] board_rdata,
    output logic                  gen_valid,
    input  logic                  gen_ready,
    output logic [5:0]            gen_square,
    output logic [3:0]            gen_piece,
    input  logic                  mv_valid,
    output logic                  mv_ready,
    input  logic [15:0]           mv_data,
    input  logic                  mv_none,
    input  logic                  mv_last,
    output logic                  ml_we,
    output logic [ADDR_WIDTH-1:0] ml_addr,
    output logic [DATA_WIDTH-1:0] ml_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            move_count,
    output logic                  overflow
);

    lmg_state_t  state, state_n, adv_state;
    logic [2:0]  row, row_n, col, col_n, adv_row, adv_col;
    logic [31:0] row_word, row_word_n;
    logic [3:0]  cur_piece;
    logic        start_q, run_start, beat_accept, last_col, last_square;

    assign cur_piece   = row_word[{col, 2'b00} +: 4];
    assign run_start   = (state == ST_IDLE) && start && !start_q;
    assign beat_accept = (state == ST_COLLECT) && mv_valid && !mv_none;
    assign board_addr  = row;

    // Where the scan goes after finishing the current square
    assign last_col    = (col == 3'd7);
    assign last_square = last_col && (row == 3'd7);
    assign adv_state   = last_square ? ST_DONE : (last_col ? ST_FETCH : ST_SCAN);
    assign adv_row     = last_col ? row + 3'd1 : row;
    assign adv_col     = col + 3'd1;

    // Start history keeps sampling through reset so a start held high across reset is not an edge
    always_ff @(posedge clk) begin
        start_q <= start;
    end

    // Scheduler state and scan position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            row_word <= '0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            row_word <= row_word_n;
        end
    end

    // Next-state, scan position and handshake outputs
    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        row_word_n = row_word;
        gen_valid  = 1'b0;
        gen_square = '0;
        gen_piece  = '0;
        mv_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run_start) begin
                    row_n   = '0;
                    col_n   = '0;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy    = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                busy       = 1'b1;
                row_word_n = board_rdata[31:0];
                col_n      = '0;
                state_n    = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (is_own_piece(cur_piece, side)) begin
                    state_n = ST_DISPATCH;
                end else begin
                    state_n = adv_state;
                    row_n   = adv_row;
                    col_n   = adv_col;
                end
            end
            ST_DISPATCH: begin
                busy       = 1'b1;
                gen_valid  = 1'b1;
                gen_square = {row, col};
                gen_piece  = cur_piece;
                if (gen_ready) begin
                    state_n = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy     = 1'b1;
                mv_ready = 1'b1;
                if (mv_valid && mv_last) begin
                    state_n = adv_state;
                    row_n   = adv_row;
                    col_n   = adv_col;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    move_list_writer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MOVE_BASE  (MOVE_BASE),
        .MAX_MOVES  (MAX_MOVES)
    ) u_writer (
        .clk        (clk),
        .reset      (reset),
        .clear      (run_start),
        .beat_valid (beat_accept),
        .beat_move  (mv_data),
        .ml_we      (ml_we),
        .ml_addr    (ml_addr),
        .ml_wdata   (ml_wdata),
        .move_count (move_count),
        .overflow   (overflow)
    );

endmodule
